// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the LED matrix link (transmit generator and receive checker).
package crc8_pkg;

   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BITCNT_W  = 3;
   localparam int unsigned STAT_W    = 16;
   localparam logic [7:0]  CRC8_POLY = 8'h8E;
   localparam logic [7:0]  CRC8_INIT = 8'h00;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_CALC = 1'b1
   } chk_state_e;

   typedef struct packed {
      logic crc_ok;
      logic len_err;
   } frame_status_t;

   // One bit-serial iteration: conditional XOR with the divisor, then shift left.
   function automatic logic [7:0] crc8_step(input logic [7:0] rem, input logic [7:0] poly);
      logic [7:0] t;
      t = rem[7] ? (rem ^ poly) : rem;
      return {t[6:0], 1'b0};
   endfunction

endpackage

// File: rtl/crc_frame_checker_if.sv
// Byte-stream bus: receive side from the deframer, forwarded payload to the frame-buffer writer.
interface crc_frame_checker_if;
   import crc8_pkg::*;

   logic [BYTE_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_last;
   logic              rx_ready;
   logic [BYTE_W-1:0] pl_data;
   logic              pl_valid;

   modport master (
      output rx_data, rx_valid, rx_last,
      input  rx_ready, pl_data, pl_valid
   );

   modport slave (
      input  rx_data, rx_valid, rx_last,
      output rx_ready, pl_data, pl_valid
   );

endinterface

// File: rtl/crc_frame_checker_engine.sv
// crc8_serial_engine: divides one loaded byte by the CRC-8 polynomial, one bit per cycle.
module crc8_serial_engine
   import crc8_pkg::*;
#(
   parameter logic [7:0] POLY = CRC8_POLY
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_load,
   input  logic [BYTE_W-1:0] i_data,
   output logic              o_done_c,
   output logic [BYTE_W-1:0] o_rem_nxt_c
);

   logic [BYTE_W-1:0]   r_rem;
   logic [BITCNT_W-1:0] r_bit_cnt;
   logic                r_busy;
   logic [BYTE_W-1:0]   w_rem_step;

   assign w_rem_step  = crc8_step(r_rem, POLY);
   assign o_rem_nxt_c = w_rem_step;
   // Asserted during the eighth iteration so the caller can capture the result on that edge.
   assign o_done_c    = r_busy && (r_bit_cnt == BITCNT_W'(BYTE_W - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem     <= '0;
         r_bit_cnt <= '0;
         r_busy    <= 1'b0;
      end else if (i_load) begin
         r_rem     <= i_data;
         r_bit_cnt <= '0;
         r_busy    <= 1'b1;
      end else if (r_busy) begin
         r_rem     <= w_rem_step;
         r_bit_cnt <= r_bit_cnt + BITCNT_W'(1);
         if (o_done_c) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC-8 frame checker: forwards payload bytes and reports CRC/length status per frame.
// Optional CRC_CHK_STATS_EN adds saturating good/bad frame counters.
module crc_frame_checker
   import crc8_pkg::*;
#(
   parameter logic [7:0]  POLY     = CRC8_POLY,
   parameter logic [7:0]  CRC_INIT = CRC8_INIT,
   parameter int unsigned MAX_LEN  = 64,
   parameter int unsigned LEN_W    = 7
) (
   input  logic                   clk,
   input  logic                   rst_n,
   crc_frame_checker_if.slave     s_bus,
   output logic                   o_frame_done,
   output logic                   o_crc_ok,
   output logic                   o_len_err,
   output logic [LEN_W-1:0]       o_frame_len
`ifdef CRC_CHK_STATS_EN
   ,
   output logic [STAT_W-1:0]      o_good_cnt,
   output logic [STAT_W-1:0]      o_bad_cnt
`endif
);

   chk_state_e        r_state, w_state_nxt;
   logic [BYTE_W-1:0] r_crc, w_crc_nxt;
   logic [LEN_W-1:0]  r_count, w_count_nxt;
   logic              r_ovf, w_ovf_nxt;
   logic              r_rx_ready, w_rx_ready_nxt;
   logic [BYTE_W-1:0] r_pl_data, w_pl_data_nxt;
   logic              r_pl_valid, w_pl_valid_nxt;
   logic              r_frame_done, w_frame_done_nxt;
   frame_status_t     r_status, w_status_nxt;
   logic [LEN_W-1:0]  r_frame_len, w_frame_len_nxt;
   logic              w_accept;
   logic              w_load;
   logic              w_eng_done_c;
   logic [BYTE_W-1:0] w_eng_rem_c;

   crc8_serial_engine #(.POLY(POLY)) u_engine (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_load      (w_load),
      .i_data      (r_crc ^ s_bus.rx_data),
      .o_done_c    (w_eng_done_c),
      .o_rem_nxt_c (w_eng_rem_c)
   );

   assign w_accept = s_bus.rx_valid && (r_state == ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_crc        <= CRC_INIT;
         r_count      <= '0;
         r_ovf        <= 1'b0;
         r_rx_ready   <= 1'b1;
         r_pl_data    <= '0;
         r_pl_valid   <= 1'b0;
         r_frame_done <= 1'b0;
         r_status     <= '0;
         r_frame_len  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_crc        <= w_crc_nxt;
         r_count      <= w_count_nxt;
         r_ovf        <= w_ovf_nxt;
         r_rx_ready   <= w_rx_ready_nxt;
         r_pl_data    <= w_pl_data_nxt;
         r_pl_valid   <= w_pl_valid_nxt;
         r_frame_done <= w_frame_done_nxt;
         r_status     <= w_status_nxt;
         r_frame_len  <= w_frame_len_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_crc_nxt        = r_crc;
      w_count_nxt      = r_count;
      w_ovf_nxt        = r_ovf;
      w_pl_data_nxt    = r_pl_data;
      w_pl_valid_nxt   = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_status_nxt     = r_status;
      w_frame_len_nxt  = r_frame_len;
      w_load           = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (s_bus.rx_last) begin
                  w_frame_done_nxt     = 1'b1;
                  w_status_nxt.crc_ok  = (s_bus.rx_data == r_crc) && !r_ovf;
                  w_status_nxt.len_err = r_ovf;
                  w_frame_len_nxt      = r_count;
                  w_crc_nxt            = CRC_INIT;
                  w_count_nxt          = '0;
                  w_ovf_nxt            = 1'b0;
               end else if (r_count < LEN_W'(MAX_LEN)) begin
                  w_load         = 1'b1;
                  w_count_nxt    = r_count + LEN_W'(1);
                  w_pl_data_nxt  = s_bus.rx_data;
                  w_pl_valid_nxt = 1'b1;
                  w_state_nxt    = ST_CALC;
               end else begin
                  // Payload beyond MAX_LEN is swallowed; only the flag records it.
                  w_ovf_nxt = 1'b1;
               end
            end
         end
         ST_CALC: begin
            if (w_eng_done_c) begin
               w_crc_nxt   = w_eng_rem_c;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      w_rx_ready_nxt = (w_state_nxt == ST_IDLE);
   end

   assign s_bus.rx_ready = r_rx_ready;
   assign s_bus.pl_data  = r_pl_data;
   assign s_bus.pl_valid = r_pl_valid;
   assign o_frame_done   = r_frame_done;
   assign o_crc_ok       = r_status.crc_ok;
   assign o_len_err      = r_status.len_err;
   assign o_frame_len    = r_frame_len;

`ifdef CRC_CHK_STATS_EN
   logic [STAT_W-1:0] r_good_cnt, w_good_nxt;
   logic [STAT_W-1:0] r_bad_cnt, w_bad_nxt;

   // Saturating pass/fail frame counters, advanced on each frame_done.
   always_comb begin
      w_good_nxt = r_good_cnt;
      w_bad_nxt  = r_bad_cnt;
      if (w_frame_done_nxt) begin
         if (w_status_nxt.crc_ok) begin
            if (r_good_cnt != {STAT_W{1'b1}}) w_good_nxt = r_good_cnt + STAT_W'(1);
         end else begin
            if (r_bad_cnt != {STAT_W{1'b1}}) w_bad_nxt = r_bad_cnt + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_good_cnt <= '0;
         r_bad_cnt  <= '0;
      end else begin
         r_good_cnt <= w_good_nxt;
         r_bad_cnt  <= w_bad_nxt;
      end
   end

   assign o_good_cnt = r_good_cnt;
   assign o_bad_cnt  = r_bad_cnt;
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// Directed bench for crc_frame_checker: default instance (MAX_LEN=64) and a MAX_LEN=4 instance.
module tb_crc_frame_checker;

   logic       clk;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_last;
   logic       tx_sel;
   logic       w_ready;

   logic       done_a, ok_a, lerr_a;
   logic [6:0] flen_a;
   logic       done_b, ok_b, lerr_b;
   logic [2:0] flen_b;
`ifdef CRC_CHK_STATS_EN
   logic [15:0] good_a, bad_a, good_b, bad_b;
`endif

   int checks = 0;
   int errors = 0;
   int pl_cnt_a = 0, pl_cnt_b = 0, done_cnt_a = 0, overlap_cnt = 0;
   int waited;
   int base_pl, base_done;

   crc_frame_checker_if bus_a ();
   crc_frame_checker_if bus_b ();

   assign bus_a.rx_data  = tx_data;
   assign bus_a.rx_last  = tx_last;
   assign bus_a.rx_valid = tx_valid & ~tx_sel;
   assign bus_b.rx_data  = tx_data;
   assign bus_b.rx_last  = tx_last;
   assign bus_b.rx_valid = tx_valid & tx_sel;
   assign w_ready        = tx_sel ? bus_b.rx_ready : bus_a.rx_ready;

   crc_frame_checker dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_bus        (bus_a),
      .o_frame_done (done_a),
      .o_crc_ok     (ok_a),
      .o_len_err    (lerr_a),
      .o_frame_len  (flen_a)
`ifdef CRC_CHK_STATS_EN
      ,
      .o_good_cnt   (good_a),
      .o_bad_cnt    (bad_a)
`endif
   );

   crc_frame_checker #(.MAX_LEN(4), .LEN_W(3)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_bus        (bus_b),
      .o_frame_done (done_b),
      .o_crc_ok     (ok_b),
      .o_len_err    (lerr_b),
      .o_frame_len  (flen_b)
`ifdef CRC_CHK_STATS_EN
      ,
      .o_good_cnt   (good_b),
      .o_bad_cnt    (bad_b)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_a.pl_valid) pl_cnt_a++;
      if (bus_b.pl_valid) pl_cnt_b++;
      if (done_a) done_cnt_a++;
      if ((bus_a.pl_valid && done_a) || (bus_b.pl_valid && done_b)) overlap_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted with rx_valid still high.
   task automatic send(input logic [7:0] d, input logic l, output int n_wait);
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      n_wait   = 0;
      while (!w_ready && n_wait < 30) begin
         @(negedge clk);
         n_wait++;
      end
      if (!w_ready) begin
         checks++;
         errors++;
         $error("FAIL send_timeout observed=ready_low expected=ready_within_30");
      end else begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic frame_chk(input string tag, input logic ok, input logic le, input logic [6:0] len);
      chk({tag, "_done"}, 16'(done_a), 16'd1);
      chk({tag, "_ok"},   16'(ok_a),   16'(ok));
      chk({tag, "_lerr"}, 16'(lerr_a), 16'(le));
      chk({tag, "_len"},  16'(flen_a), 16'(len));
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      tx_sel   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready",  16'(bus_a.rx_ready), 16'd1);
      chk("rst_plv",    16'(bus_a.pl_valid), 16'd0);
      chk("rst_pld",    16'(bus_a.pl_data),  16'd0);
      chk("rst_done",   16'(done_a),         16'd0);
      chk("rst_ok",     16'(ok_a),           16'd0);
      chk("rst_len",    16'(flen_a),         16'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-byte frame, matching CRC
      base_pl = pl_cnt_a;
      send(8'h01, 1'b0, waited);
      chk("f1_plv", 16'(bus_a.pl_valid), 16'd1);
      chk("f1_pld", 16'(bus_a.pl_data),  16'h01);
      send(8'h1C, 1'b1, waited);
      tx_valid = 1'b0;
      frame_chk("f1", 1'b1, 1'b0, 7'd1);
      chk("f1_plcnt", 16'(pl_cnt_a - base_pl), 16'd1);
      @(negedge clk);
      chk("f1_done_pulse", 16'(done_a), 16'd0);
      chk("f1_hold_ok",    16'(ok_a),   16'd1);

      // Single-byte frame, corrupted CRC
      send(8'h01, 1'b0, waited);
      send(8'h1D, 1'b1, waited);
      tx_valid = 1'b0;
      frame_chk("f2", 1'b0, 1'b0, 7'd1);

      // Two-byte frame with source holding rx_valid through the busy window
      send(8'h01, 1'b0, waited);
      send(8'h01, 1'b0, waited);
      chk("f3_busy_cycles", 16'(waited), 16'd8);
      send(8'h50, 1'b1, waited);
      chk("f3_last_wait", 16'(waited), 16'd8);
      tx_valid = 1'b0;
      frame_chk("f3", 1'b1, 1'b0, 7'd2);

      // Zero-length frame followed back-to-back by a fresh frame
      send(8'h00, 1'b1, waited);
      frame_chk("f4", 1'b1, 1'b0, 7'd0);
      send(8'h01, 1'b0, waited);
      chk("f5_b2b_wait", 16'(waited), 16'd0);
      send(8'h1C, 1'b1, waited);
      tx_valid = 1'b0;
      frame_chk("f5", 1'b1, 1'b0, 7'd1);
`ifdef CRC_CHK_STATS_EN
      chk("stat_good", good_a, 16'd4);
      chk("stat_bad",  bad_a,  16'd1);
`endif

      // Overflow on the MAX_LEN=4 instance
      tx_sel  = 1'b1;
      base_pl = pl_cnt_b;
      for (int i = 0; i < 6; i++) send(8'h00, 1'b0, waited);
      send(8'h00, 1'b1, waited);
      tx_valid = 1'b0;
      chk("ovf_done", 16'(done_b), 16'd1);
      chk("ovf_ok",   16'(ok_b),   16'd0);
      chk("ovf_lerr", 16'(lerr_b), 16'd1);
      chk("ovf_len",  16'(flen_b), 16'd4);
      chk("ovf_plcnt", 16'(pl_cnt_b - base_pl), 16'd4);
`ifdef CRC_CHK_STATS_EN
      chk("ovf_stat_bad", bad_b, 16'd1);
`endif
      tx_sel = 1'b0;
      @(negedge clk);

      // Reset asserted while the second payload byte is being divided
      send(8'h01, 1'b0, waited);
      send(8'h01, 1'b0, waited);
      tx_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_plv",  16'(bus_a.pl_valid), 16'd0);
      chk("mrst_pld",  16'(bus_a.pl_data),  16'd0);
      chk("mrst_done", 16'(done_a),         16'd0);
      chk("mrst_ok",   16'(ok_a),           16'd0);
      chk("mrst_lerr", 16'(lerr_a),         16'd0);
      chk("mrst_len",  16'(flen_a),         16'd0);
`ifdef CRC_CHK_STATS_EN
      chk("mrst_good", good_a, 16'd0);
      chk("mrst_bad",  bad_a,  16'd0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      base_done = done_cnt_a;
      repeat (10) @(negedge clk);
      send(8'h01, 1'b0, waited);
      send(8'h1C, 1'b1, waited);
      tx_valid = 1'b0;
      frame_chk("f6", 1'b1, 1'b0, 7'd1);
      @(negedge clk);
      chk("mrst_no_pulse", 16'(done_cnt_a - base_done), 16'd1);
`ifdef CRC_CHK_STATS_EN
      chk("f6_good", good_a, 16'd1);
      chk("f6_bad",  bad_a,  16'd0);
`endif
      chk("no_overlap", 16'(overlap_cnt), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_frame_checker.md
Name: crc_frame_checker

Overview:
Receive-side counterpart of the LED matrix link's CRC-8 generator. It accepts a byte stream whose final byte is a CRC-8, recomputes the CRC over the payload bit-serially, and forwards payload bytes downstream. At end of frame it reports pass/fail and length status. It sits between the byte receiver (UART/SPI deframer) and the matrix frame-buffer writer.

Parameters:
POLY, 8'h8E, CRC-8 divisor; must match the transmit-side generator.
CRC_INIT, 8'h00, running CRC value at the start of every frame.
MAX_LEN, 64, maximum number of payload bytes per frame (CRC byte excluded).
LEN_W, 7, width of frame_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data is valid
rx_last  input  1  qualifies rx_data as the CRC byte that ends the frame
rx_ready  output  1  block can accept a byte this cycle
pl_data  output  8  forwarded payload byte
pl_valid  output  1  one-cycle pulse; pl_data is valid (no backpressure)
frame_done  output  1  one-cycle pulse at end of frame
crc_ok  output  1  CRC matched and no length error; valid when frame_done=1
len_err  output  1  payload exceeded MAX_LEN; valid when frame_done=1
frame_len  output  LEN_W  payload byte count, saturating at MAX_LEN; valid when frame_done=1

Behaviour:
- Reset is asynchronous and active-low. Reset forces state IDLE and crc_reg=CRC_INIT. It clears byte count, overflow flag, bit counter, pl_valid, frame_done, crc_ok, len_err, frame_len and pl_data. Reset mid-frame discards the partial frame and emits no pulse.
- A byte is accepted when rx_valid && rx_ready on a rising clk edge.
- rx_ready = 1 only in IDLE.
- IDLE, payload byte accepted (rx_last=0):
  - If count < MAX_LEN: rem <= crc_reg ^ rx_data, count++, pl_data <= rx_data, pl_valid pulses the next cycle, go to CALC with bit_cnt=0.
  - If count == MAX_LEN: set the overflow flag, do not forward, do not update crc_reg, stay in IDLE. The byte is swallowed.
- CALC: rx_ready=0. Each cycle:
  - If rem[7]=1, rem = rem ^ POLY; then rem = rem << 1 (8-bit, MSB lost; XOR first, then shift).
  - bit_cnt++.
  - On the 8th iteration, crc_reg <= the result and return to IDLE.
  - Busy exactly 8 cycles, so payload throughput is 1 byte per 9 cycles.
- Single-byte equivalence: with CRC_INIT=0, a one-byte payload yields exactly the transmit generator's combinational CRC of that byte.
- IDLE, CRC byte accepted (rx_last=1):
  - The next cycle, frame_done=1 for one cycle.
  - crc_ok = (rx_data == crc_reg) && !overflow.
  - len_err = overflow.
  - frame_len = count.
  - Then crc_reg <= CRC_INIT, count and overflow clear, state stays IDLE. A new frame may start on the very next cycle.
- Zero-length frame (first byte has rx_last): compared against CRC_INIT; frame_len=0.
- frame_done, crc_ok, len_err and frame_len hold their values until the next frame_done. Only the frame_done pulse qualifies them.
- rx_valid while rx_ready=0 is ignored; the source must hold the byte.
- pl_valid and frame_done never assert in the same cycle.

Optional Feature:
CRC_CHK_STATS_EN:
- When defined, adds outputs good_cnt[15:0] and bad_cnt[15:0].
- On each frame_done, increment good_cnt if crc_ok, else bad_cnt. Both saturate at 16'hFFFF and clear on reset.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package crc8_pkg holds CRC8_POLY=8'h8E, CRC8_INIT=8'h00, and a crc8_step function (one XOR-then-shift iteration). The transmit generator and this checker both use it.
- Natural sub-module: crc8_serial_engine, which owns rem, bit_cnt, load/busy/done. The checker's FSM (IDLE/CALC) and the length/overflow logic sit above it.

Test Plan:
- Frame [0x01, last 0x1C] -> pl_valid once with 0x01; frame_done, crc_ok=1, len_err=0, frame_len=1.
- Frame [0x01, last 0x1D] -> frame_done, crc_ok=0, frame_len=1.
- Frame [0x01, 0x01, last 0x50] -> crc_ok=1, frame_len=2. rx_ready is low for 8 cycles after each payload byte; rx_valid held during busy is accepted only when ready returns.
- Zero-length frame [last 0x00] -> crc_ok=1, frame_len=0. Back-to-back frames with rx_valid held high -> second frame result is unaffected by the first (crc_reg reinitialised).
- MAX_LEN=4, send 6 zero payload bytes then last 0x00 -> only 4 pl_valid pulses; frame_done with len_err=1, crc_ok=0, frame_len=4.
- Assert rst_n low during CALC of byte 2 -> no frame_done; all outputs 0. A following frame [0x01, last 0x1C] passes. With CRC_CHK_STATS_EN, good_cnt/bad_cnt track pass/fail and saturate.
